// File: rtl/npu_pkg.sv
// npu_pkg: constants and types shared by the pixel feeder and the convolution engine.
//   IMG_WIDTH/IMG_HEIGHT/PIX_W : frame geometry and pixel width
//   PIX_ADDR_W                 : raster address width
//   feeder_state_t             : pixel_stream_feeder FSM states
package npu_pkg;
    localparam int IMG_WIDTH  = 32;
    localparam int IMG_HEIGHT = 32;
    localparam int PIX_W      = 8;
    localparam int PIX_ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, FINISH} feeder_state_t;
endpackage

// File: rtl/pixel_stream_feeder_frame_ram.sv
// frame_ram: one write port, one synchronous read port (latency 1).
//   we/wr_addr/wr_data : write port
//   re/rd_addr         : read request; rd_data updates one cycle later
//   rd_data            : held while re=0; only this register is reset, never the array
module frame_ram import npu_pkg::*; #(
    parameter int DEPTH = IMG_WIDTH * IMG_HEIGHT,
    parameter int WIDTH = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder: streams a host-loaded frame in raster order to the convolution engine.
//   wr_en/wr_addr/wr_data : host frame write, accepted in IDLE only; wr_err pulses when dropped
//   go/pause              : start a frame (IDLE only) / per-cycle issue throttle
//   start_signal, pixel_in, pixel_valid : engine-facing stream
//   done_signal           : engine completion, honoured only in WAIT_DONE
//   busy, frame_done, timeout_err        : status
module pixel_stream_feeder import npu_pkg::*; #(
    parameter int IMG_WIDTH  = npu_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = npu_pkg::IMG_HEIGHT,
    parameter int PIX_W      = npu_pkg::PIX_W,
    parameter int TIMEOUT    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
    input  logic [PIX_W-1:0]                       wr_data,
    output logic                                   wr_err,
    input  logic                                   go,
    input  logic                                   pause,
    output logic                                   start_signal,
    output logic [PIX_W-1:0]                       pixel_in,
    output logic                                   pixel_valid,
    input  logic                                   done_signal,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   timeout_err
);
    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT) + 1;

    feeder_state_t  state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           to_q, to_d;
    logic           valid_q, wr_err_q, issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            valid_q  <= issue;
            wr_err_q <= wr_en && state_q != IDLE;
        end
    end

    // cnt_d defaults to 0 so the timeout counter is already clear on WAIT_DONE entry;
    // to_d is a one-cycle flag that lands exactly on the FINISH cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        to_d    = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: state_d = go ? START : IDLE;
            START: begin
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: if (!pause) begin
                issue   = 1'b1;
                idx_d   = idx_q + AW'(1);
                state_d = (idx_q == AW'(N - 1)) ? WAIT_DONE : STREAM;
            end
            WAIT_DONE: begin
                if (done_signal) state_d = FINISH;
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = FINISH;
                    to_d    = 1'b1;
                end else cnt_d = cnt_q + CW'(1);
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    frame_ram #(.DEPTH(N), .WIDTH(PIX_W), .AW(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en && state_q == IDLE),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .re      (issue),
        .rd_addr (idx_q),
        .rd_data (pixel_in)
    );

    assign start_signal = state_q == START;
    assign busy         = state_q != IDLE;
    assign frame_done   = state_q == FINISH;
    assign pixel_valid  = valid_q;
    assign timeout_err  = to_q;
    assign wr_err       = wr_err_q;
endmodule

// File: tb/tb_pixel_stream_feeder.sv
// tb_pixel_stream_feeder: directed self-checking bench for pixel_stream_feeder.
module tb_pixel_stream_feeder;
    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       rst, wr_en, go, pause, done_signal;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_err, start_signal, pixel_valid, busy, frame_done, timeout_err;
    logic [7:0] pixel_in;
    logic [7:0] exp_mem [N];
    int         n_assert = 0;
    int         n_fail = 0;
    int         fd;

    pixel_stream_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .go(go), .pause(pause), .start_signal(start_signal),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .done_signal(done_signal),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit flat);
        for (int a = 0; a < N; a++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(a);
            wr_data = flat ? 8'd10 : 8'(a);
            exp_mem[a] = wr_data;
            step();
            chk("wr_err_idle", wr_err, 0);
        end
        wr_en = 1'b0;
    endtask

    // Cycle c is observed at the negedge following the c-th posedge after go was driven;
    // inputs set while observing cycle c are sampled in cycle c.
    task automatic run_frame(input bit pmode, input bit send_done, input bit mid,
                             input int abort_at, output int fd_cyc);
        int c = 0, iss = 0, pix = 0, last = -1, exp_fd = -1;
        bit v_now = 1'b0;
        fd_cyc = -1;
        go = 1'b1;
        while (c < 4000) begin
            step();
            c++;
            if (c == 1) go = 1'b0;
            if (mid && c == 101) begin
                go    = 1'b0;
                wr_en = 1'b0;
            end
            chk("start_signal", start_signal, c == 1);
            chk("busy", busy, 1);
            chk("pixel_valid", pixel_valid, v_now);
            chk("wr_err", wr_err, mid && c == 101);
            if (v_now) begin
                chk("pixel_in", pixel_in, exp_mem[pix]);
                if (pix == abort_at) begin
                    rst = 1'b1;
                    pause = 1'b0;
                    step();
                    chk("abort_valid", pixel_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_pixel_in", pixel_in, 0);
                    rst = 1'b0;
                    step();
                    return;
                end
                pix++;
                if (pix == N) begin
                    last   = c;
                    exp_fd = send_done ? c + 2 : c + 16;
                end
            end
            chk("frame_done", frame_done, c == exp_fd);
            chk("timeout_err", timeout_err, c == exp_fd && !send_done);
            if (frame_done || c == exp_fd) begin
                fd_cyc = c;
                break;
            end
            done_signal = send_done ? (last > 0 && c == last + 1) : (c == 50);
            pause = pmode && (c % 3 == 0);
            v_now = c >= 2 && iss < N && !pause;
            if (v_now) iss++;
            if (mid && c == 100) begin
                go      = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 10'd5;
                wr_data = 8'hAA;
            end
        end
        pause = 1'b0;
        done_signal = 1'b0;
        chk("frame_done_seen", fd_cyc >= 0, 1);
        step();
        chk("busy_after", busy, 0);
        chk("frame_done_after", frame_done, 0);
        chk("timeout_after", timeout_err, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; go = 1'b0; pause = 1'b0; done_signal = 1'b0;
        wr_addr = '0; wr_data = '0;
        @(negedge clk);
        step();
        chk("rst_start", start_signal, 0);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_pixel_in", pixel_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        step();

        load(1'b0);
        run_frame(1'b0, 1'b1, 1'b0, -1, fd);
        chk("nominal_fd_cycle", fd, 1028);

        run_frame(1'b1, 1'b1, 1'b0, -1, fd);

        run_frame(1'b0, 1'b1, 1'b1, -1, fd);
        chk("mid_fd_cycle", fd, 1028);

        run_frame(1'b0, 1'b0, 1'b0, -1, fd);
        chk("timeout_fd_cycle", fd, 1026 + 16);

        run_frame(1'b0, 1'b1, 1'b0, 500, fd);
        run_frame(1'b0, 1'b1, 1'b0, -1, fd);
        chk("post_abort_fd_cycle", fd, 1028);

        load(1'b1);
        run_frame(1'b0, 1'b1, 1'b0, -1, fd);
        chk("flat_fd_cycle", fd, 1028);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
